// File: rtl/alu_mdu_pkg.sv
// rtl/alu_mdu_pkg.sv - op codes, FSM state type and operand helpers for alu_mdu_seq
package alu_mdu_pkg;

   // Base ALU / branch-compare encodings (0-15)
   localparam logic [4:0] OP_ADD    = 5'd0;
   localparam logic [4:0] OP_SUB    = 5'd1;
   localparam logic [4:0] OP_SLL    = 5'd2;
   localparam logic [4:0] OP_SLTS   = 5'd3;
   localparam logic [4:0] OP_SLTU   = 5'd4;
   localparam logic [4:0] OP_XOR    = 5'd5;
   localparam logic [4:0] OP_SRL    = 5'd6;
   localparam logic [4:0] OP_SRA    = 5'd7;
   localparam logic [4:0] OP_OR     = 5'd8;
   localparam logic [4:0] OP_AND    = 5'd9;
   localparam logic [4:0] OP_EQ     = 5'd10;
   localparam logic [4:0] OP_NE     = 5'd11;
   localparam logic [4:0] OP_LTS    = 5'd12;
   localparam logic [4:0] OP_GES    = 5'd13;
   localparam logic [4:0] OP_LTU    = 5'd14;
   localparam logic [4:0] OP_GEU    = 5'd15;
   // M-extension encodings (16-23); 24-31 are reserved
   localparam logic [4:0] OP_MUL    = 5'd16;
   localparam logic [4:0] OP_MULH   = 5'd17;
   localparam logic [4:0] OP_MULHSU = 5'd18;
   localparam logic [4:0] OP_MULHU  = 5'd19;
   localparam logic [4:0] OP_DIV    = 5'd20;
   localparam logic [4:0] OP_DIVU   = 5'd21;
   localparam logic [4:0] OP_REM    = 5'd22;
   localparam logic [4:0] OP_REMU   = 5'd23;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   // Working width of the helpers; callers cast in and truncate out, so any
   // XLEN up to 64 (product width 128) is covered.
   localparam int MAXW = 128;

   // Extend a w-bit value (zero-extended into v) with sign bit s.
   function automatic logic [MAXW-1:0] sext_w(input logic [MAXW-1:0] v,
                                              input int unsigned      w,
                                              input logic             s);
      logic [MAXW-1:0] hi;
      hi = ~({MAXW{1'b1}} >> (MAXW - w));
      return s ? (v | hi) : v;
   endfunction

   // Two's-complement magnitude when neg is set; the low bits hold |v|.
   function automatic logic [MAXW-1:0] mag_w(input logic [MAXW-1:0] v,
                                             input logic             neg);
      return neg ? (~v + MAXW'(1)) : v;
   endfunction

   function automatic logic is_mul_op(input logic [4:0] o);
      return (o[4:3] == 2'b10) && !o[2];
   endfunction

   function automatic logic is_div_op(input logic [4:0] o);
      return (o[4:3] == 2'b10) && o[2];
   endfunction

endpackage

// File: rtl/alu_mdu_divcore.sv
// rtl/alu_mdu_divcore.sv - iterative unsigned restoring divider, one quotient bit per clock
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   start_i         load operands and begin XLEN iterations
//   dividend_i      unsigned dividend (magnitude)
//   divisor_i       unsigned divisor (magnitude, non-zero)
//   busy_o          iterations in progress
//   done_o          quotient/remainder valid, held until the next start
//   quotient_o      unsigned quotient
//   remainder_o     unsigned remainder
module alu_mdu_divcore #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start_i,
   input  logic [XLEN-1:0] dividend_i,
   input  logic [XLEN-1:0] divisor_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] quotient_o,
   output logic [XLEN-1:0] remainder_o
);

   localparam int CW = $clog2(XLEN + 1);

   logic [XLEN-1:0] rem_q, quo_q, dvs_q;
   logic [CW-1:0]   cnt_q;
   logic            busy_q, done_q;

   // Partial remainder needs one extra bit: 2*rem+1 can exceed XLEN bits.
   logic [XLEN:0] rem_sh, trial;

   always_comb begin
      rem_sh = {rem_q, quo_q[XLEN-1]};
      trial  = rem_sh - {1'b0, dvs_q};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rem_q  <= '0;
         quo_q  <= '0;
         dvs_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else if (start_i) begin
         rem_q  <= '0;
         quo_q  <= dividend_i;
         dvs_q  <= divisor_i;
         cnt_q  <= '0;
         busy_q <= 1'b1;
         done_q <= 1'b0;
      end else if (busy_q) begin
         // Dividend bits shift out of quo_q as quotient bits shift in.
         if (!trial[XLEN]) begin
            rem_q <= trial[XLEN-1:0];
            quo_q <= {quo_q[XLEN-2:0], 1'b1};
         end else begin
            rem_q <= rem_sh[XLEN-1:0];
            quo_q <= {quo_q[XLEN-2:0], 1'b0};
         end
         if (cnt_q == CW'(XLEN - 1)) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
         end
         cnt_q <= cnt_q + CW'(1);
      end
   end

   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign quotient_o  = quo_q;
   assign remainder_o = rem_q;

endmodule

// File: rtl/alu_mdu_seq.sv
// rtl/alu_mdu_seq.sv - pipelined RV32I ALU with iterative RV M-extension multiply/divide
//
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   in_valid/ready   operation handshake from the execute-stage decoder
//   op               0-15 base ALU/compare, 16-23 MUL..REMU, 24-31 reserved (result 0)
//   a, b             operands
//   out_valid/ready  result handshake to writeback
//   result           registered ALU/MDU result
//   flag             registered branch-compare result (ops 10-15), else 0
//
// Build option: ALU_MDU_FAST_MUL_EN - when defined, MUL ops use a single
// combinational multiply registered on accept (latency as base ops) and the
// MUL state is never entered.
module alu_mdu_seq
   import alu_mdu_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int SHW  = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [4:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            flag
);

   localparam int CW = $clog2(XLEN + 1);
   localparam int PW = 2 * XLEN;

   state_e          state_q, state_d;
   logic            out_valid_q, out_valid_d;
   logic [XLEN-1:0] result_q, result_d;
   logic            flag_q, flag_d;
   logic [4:0]      op_q, op_d;
   logic            neg_q, neg_d;
   logic [PW-1:0]   acc_q, acc_d;
   logic [PW-1:0]   mcand_q, mcand_d;
   logic [XLEN-1:0] mplier_q, mplier_d;
   logic            bsgn_q, bsgn_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   logic            accept;
   logic [SHW-1:0]  shamt;
   logic [XLEN-1:0] base_res;
   logic            base_flag;

   assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;
   assign shamt    = b[SHW-1:0];

   always_comb begin
      base_res  = '0;
      base_flag = 1'b0;
      case (op)
         OP_ADD:  base_res = a + b;
         OP_SUB:  base_res = a - b;
         OP_SLL:  base_res = a << shamt;
         OP_SLTS: base_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
         OP_SLTU: base_res = {{(XLEN-1){1'b0}}, a < b};
         OP_XOR:  base_res = a ^ b;
         OP_SRL:  base_res = a >> shamt;
         OP_SRA:  base_res = $unsigned($signed(a) >>> shamt);
         OP_OR:   base_res = a | b;
         OP_AND:  base_res = a & b;
         OP_EQ:   base_flag = (a == b);
         OP_NE:   base_flag = (a != b);
         OP_LTS:  base_flag = $signed(a) < $signed(b);
         OP_GES:  base_flag = $signed(a) >= $signed(b);
         OP_LTU:  base_flag = a < b;
         OP_GEU:  base_flag = a >= b;
         default: ;
      endcase
   end

   // Multiply operands sign-fixed to the product width. The iterative path
   // only walks the XLEN bits of b and folds b's sign into the last step.
   logic          mul_a_sgn, mul_b_sgn;
   logic [PW-1:0] mul_a_ext;

   assign mul_a_sgn = (op != OP_MULHU);
   assign mul_b_sgn = (op == OP_MUL) || (op == OP_MULH);
   assign mul_a_ext = PW'(sext_w(MAXW'(a), XLEN, mul_a_sgn & a[XLEN-1]));

`ifdef ALU_MDU_FAST_MUL_EN
   logic [PW-1:0] mul_b_ext, prod_fast;
   assign mul_b_ext = PW'(sext_w(MAXW'(b), XLEN, mul_b_sgn & b[XLEN-1]));
   assign prod_fast = mul_a_ext * mul_b_ext;
`endif

   // Divide: magnitudes go to the core; sign is restored when it finishes.
   logic            div_sgn, div_ovf, div_start, div_busy, div_done;
   logic [XLEN-1:0] div_a_mag, div_b_mag, div_quo, div_rem, div_sel;

   assign div_sgn   = (op == OP_DIV) || (op == OP_REM);
   assign div_ovf   = div_sgn && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
   assign div_a_mag = XLEN'(mag_w(MAXW'(a), div_sgn & a[XLEN-1]));
   assign div_b_mag = XLEN'(mag_w(MAXW'(b), div_sgn & b[XLEN-1]));
   assign div_sel   = ((op_q == OP_DIV) || (op_q == OP_DIVU)) ? div_quo : div_rem;

   alu_mdu_divcore #(.XLEN(XLEN)) u_divcore (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_i     (div_start),
      .dividend_i  (div_a_mag),
      .divisor_i   (div_b_mag),
      .busy_o      (div_busy),
      .done_o      (div_done),
      .quotient_o  (div_quo),
      .remainder_o (div_rem)
   );

   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q;
      result_d    = result_q;
      flag_d      = flag_q;
      op_d        = op_q;
      neg_d       = neg_q;
      acc_d       = acc_q;
      mcand_d     = mcand_q;
      mplier_d    = mplier_q;
      bsgn_d      = bsgn_q;
      cnt_d       = cnt_q;
      div_start   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (out_ready) out_valid_d = 1'b0;
            if (accept) begin
               op_d   = op;
               flag_d = 1'b0;
               if (is_mul_op(op)) begin
`ifdef ALU_MDU_FAST_MUL_EN
                  result_d    = (op == OP_MUL) ? prod_fast[XLEN-1:0] : prod_fast[PW-1:XLEN];
                  out_valid_d = 1'b1;
`else
                  acc_d    = '0;
                  mcand_d  = mul_a_ext;
                  mplier_d = b;
                  bsgn_d   = mul_b_sgn;
                  cnt_d    = '0;
                  state_d  = ST_MUL;
`endif
               end else if (is_div_op(op)) begin
                  if (b == '0) begin
                     result_d    = ((op == OP_DIV) || (op == OP_DIVU)) ? '1 : a;
                     out_valid_d = 1'b1;
                  end else if (div_ovf) begin
                     result_d    = (op == OP_DIV) ? a : '0;
                     out_valid_d = 1'b1;
                  end else begin
                     neg_d     = (op == OP_DIV) ? (a[XLEN-1] ^ b[XLEN-1]) :
                                 (op == OP_REM) ? a[XLEN-1] : 1'b0;
                     div_start = 1'b1;
                     state_d   = ST_DIV;
                  end
               end else begin
                  result_d    = base_res;
                  flag_d      = base_flag;
                  out_valid_d = 1'b1;
               end
            end
         end
         ST_MUL: begin
            if (cnt_q == CW'(XLEN)) begin
               result_d    = (op_q == OP_MUL) ? acc_q[XLEN-1:0] : acc_q[PW-1:XLEN];
               out_valid_d = 1'b1;
               state_d     = ST_DONE;
            end else begin
               // b's top bit weighs -2^(XLEN-1) when b is signed.
               if (mplier_q[0]) begin
                  if (bsgn_q && (cnt_q == CW'(XLEN - 1))) acc_d = acc_q - mcand_q;
                  else                                    acc_d = acc_q + mcand_q;
               end
               mcand_d  = mcand_q << 1;
               mplier_d = mplier_q >> 1;
               cnt_d    = cnt_q + CW'(1);
            end
         end
         ST_DIV: begin
            if (div_done && !div_busy) begin
               result_d    = neg_q ? (~div_sel + XLEN'(1)) : div_sel;
               out_valid_d = 1'b1;
               state_d     = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         flag_q      <= 1'b0;
         op_q        <= '0;
         neg_q       <= 1'b0;
         acc_q       <= '0;
         mcand_q     <= '0;
         mplier_q    <= '0;
         bsgn_q      <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         flag_q      <= flag_d;
         op_q        <= op_d;
         neg_q       <= neg_d;
         acc_q       <= acc_d;
         mcand_q     <= mcand_d;
         mplier_q    <= mplier_d;
         bsgn_q      <= bsgn_d;
         cnt_q       <= cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign flag      = flag_q;

endmodule

// File: tb/tb_alu_mdu_seq.sv
// tb/tb_alu_mdu_seq.sv - self-checking bench for alu_mdu_seq (XLEN=32) against an arithmetic reference model
module tb_alu_mdu_seq;

   logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready, flag;
   logic [4:0]  op;
   logic [31:0] a, b, result;

   int checks   = 0;
   int failures = 0;

   alu_mdu_seq #(.XLEN(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flag      (flag)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Reference model: RISC-V semantics with plain integer arithmetic.
   function automatic void model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] r, output logic f);
      int          sx, sy;
      longint      p;
      logic [63:0] pu;
      sx = x;
      sy = y;
      r  = '0;
      f  = 1'b0;
      case (o)
         5'd0:  r = x + y;
         5'd1:  r = x - y;
         5'd2:  r = x << y[4:0];
         5'd3:  r = {31'b0, sx < sy};
         5'd4:  r = {31'b0, x < y};
         5'd5:  r = x ^ y;
         5'd6:  r = x >> y[4:0];
         5'd7:  r = sx >>> y[4:0];
         5'd8:  r = x | y;
         5'd9:  r = x & y;
         5'd10: f = (x == y);
         5'd11: f = (x != y);
         5'd12: f = (sx < sy);
         5'd13: f = (sx >= sy);
         5'd14: f = (x < y);
         5'd15: f = (x >= y);
         5'd16: r = x * y;
         5'd17: begin p = longint'(sx) * longint'(sy); r = p[63:32]; end
         5'd18: begin p = longint'(sx) * longint'({32'b0, y}); r = p[63:32]; end
         5'd19: begin pu = {32'b0, x} * {32'b0, y}; r = pu[63:32]; end
         5'd20: if (y == 0) r = '1; else if (x == 32'h80000000 && y == 32'hFFFFFFFF) r = x; else r = sx / sy;
         5'd21: if (y == 0) r = '1; else r = x / y;
         5'd22: if (y == 0) r = x; else if (x == 32'h80000000 && y == 32'hFFFFFFFF) r = 0; else r = sx % sy;
         5'd23: if (y == 0) r = x; else r = x % y;
         default: r = '0;
      endcase
   endfunction

   // Clock edges after the accept edge until out_valid is seen.
   function automatic int exp_edges(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
      if (o >= 16 && o <= 19) begin
`ifdef ALU_MDU_FAST_MUL_EN
         return 0;
`else
         return 33;
`endif
      end
      if (o >= 20 && o <= 23) begin
         if (y == 0) return 0;
         if ((o == 20 || o == 22) && x == 32'h80000000 && y == 32'hFFFFFFFF) return 0;
         return 33;
      end
      return 0;
   endfunction

   function automatic logic [31:0] rnd_operand();
      case ($urandom_range(0, 7))
         0:       return 32'h00000000;
         1:       return 32'hFFFFFFFF;
         2:       return 32'h80000000;
         3:       return 32'h7FFFFFFF;
         4:       return 32'($urandom_range(0, 15));
         default: return $urandom();
      endcase
   endfunction

   function automatic logic [4:0] rnd_base_op();
      int r;
      r = $urandom_range(0, 23);
      if (r >= 16) r = r + 8;
      return 5'(r);
   endfunction

   // Offer one op with out_ready=1 and report what came back.
   task automatic do_op(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] r, output logic f, output int edges,
                        output bit rdy_seen, output bit tmo);
      int n;
      op = o; a = x; b = y; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      edges    = 0;
      rdy_seen = 1'b0;
      while (!out_valid && edges < 100) begin
         if (in_ready) rdy_seen = 1'b1;
         @(posedge clk); #1;
         edges++;
      end
      tmo = !out_valid;
      r   = result;
      f   = flag;
   endtask

   task automatic test_reset();
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++;
      if (result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=00000000", result); end
      checks++;
      if (flag !== 1'b0) begin failures++; $display("FAIL reset_flag got=%b exp=0", flag); end
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
   endtask

   task automatic run_and_check(input string name, input logic [4:0] o, input logic [31:0] x,
                                input logic [31:0] y, input bit check_busy);
      logic [31:0] r, er;
      logic        f, ef;
      int          e, ee;
      bit          rs, tmo;
      model(o, x, y, er, ef);
      ee = exp_edges(o, x, y);
      do_op(o, x, y, r, f, e, rs, tmo);
      checks++;
      if (tmo || r !== er || f !== ef) begin
         failures++;
         $display("FAIL %s op=%0d a=%h b=%h got result=%h flag=%b exp result=%h flag=%b timeout=%0d",
                  name, o, x, y, r, f, er, ef, tmo);
      end
      checks++;
      if (e !== ee) begin
         failures++;
         $display("FAIL %s_latency op=%0d got=%0d edges exp=%0d", name, o, e, ee);
      end
      if (check_busy) begin
         checks++;
         if (rs !== 1'b0) begin failures++; $display("FAIL %s_busy_in_ready got=1 exp=0", name); end
      end
   endtask

   task automatic test_base_directed();
      run_and_check("add_wrap", 5'd0,  32'hFFFFFFFF, 32'h1, 0);
      run_and_check("sra",      5'd7,  32'h80000000, 32'h24, 0);
      run_and_check("lts",      5'd12, 32'hFFFFFFFF, 32'h1, 0);
      run_and_check("ltu",      5'd14, 32'hFFFFFFFF, 32'h1, 0);
      run_and_check("reserved", 5'd27, 32'h12345678, 32'h9, 0);
   endtask

   task automatic test_base_random();
      for (int i = 0; i < 40; i++)
         run_and_check("base_rand", rnd_base_op(), rnd_operand(), rnd_operand(), 0);
   endtask

   task automatic test_back_to_back();
      logic [4:0]  o;
      logic [31:0] x, y, er;
      logic        ef;
      int          n;
      out_ready = 1'b1;
      n = 0;
      while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
      for (int i = 0; i < 12; i++) begin
         o = rnd_base_op(); x = rnd_operand(); y = rnd_operand();
         op = o; a = x; b = y; in_valid = 1'b1;
         checks++;
         if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready i=%0d got=%b exp=1", i, in_ready); end
         @(posedge clk); #1;
         model(o, x, y, er, ef);
         checks++;
         if (out_valid !== 1'b1 || result !== er || flag !== ef) begin
            failures++;
            $display("FAIL b2b i=%0d op=%0d valid=%b result=%h flag=%b exp result=%h flag=%b",
                     i, o, out_valid, result, flag, er, ef);
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_mul();
      run_and_check("mulh_min", 5'd17, 32'h80000000, 32'h80000000, 1);
      for (int i = 0; i < 8; i++)
         run_and_check("mul_rand", 5'(16 + $urandom_range(0, 3)), rnd_operand(), rnd_operand(), 1);
   endtask

   task automatic test_div();
      logic [4:0]  o;
      logic [31:0] x, y;
      run_and_check("div_neg7_2",  5'd20, 32'hFFFFFFF9, 32'h2, 1);
      run_and_check("rem_neg7_2",  5'd22, 32'hFFFFFFF9, 32'h2, 1);
      run_and_check("divu_zero",   5'd21, 32'h1234ABCD, 32'h0, 0);
      run_and_check("remu_zero",   5'd23, 32'h1234ABCD, 32'h0, 0);
      run_and_check("div_ovf",     5'd20, 32'h80000000, 32'hFFFFFFFF, 0);
      run_and_check("rem_ovf",     5'd22, 32'h80000000, 32'hFFFFFFFF, 0);
      for (int i = 0; i < 12; i++) begin
         o = 5'(20 + $urandom_range(0, 3));
         x = rnd_operand();
         y = rnd_operand();
         run_and_check("div_rand", o, x, y, 1);
      end
   endtask

   task automatic test_backpressure();
      logic [4:0]  o1, o2;
      logic [31:0] x1, y1, x2, y2, er1, er2;
      logic        ef1, ef2;
      int          n;
      out_ready = 1'b1;
      n = 0;
      while ((!in_ready || out_valid) && n < 100) begin @(posedge clk); #1; n++; end
      o1 = 5'd12; x1 = $urandom(); y1 = $urandom();
      o2 = rnd_base_op(); x2 = rnd_operand(); y2 = rnd_operand();
      model(o1, x1, y1, er1, ef1);
      model(o2, x2, y2, er2, ef2);
      out_ready = 1'b0;
      op = o1; a = x1; b = y1; in_valid = 1'b1;
      @(posedge clk); #1;
      op = o2; a = x2; b = y2;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (out_valid !== 1'b1 || result !== er1 || flag !== ef1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_hold cycle=%0d valid=%b result=%h flag=%b in_ready=%b exp valid=1 result=%h flag=%b in_ready=0",
                     i, out_valid, result, flag, in_ready, er1, ef1);
         end
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_in_ready got=%b exp=1", in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || result !== er2 || flag !== ef2) begin
         failures++;
         $display("FAIL bp_next_op valid=%b result=%h flag=%b exp result=%h flag=%b",
                  out_valid, result, flag, er2, ef2);
      end
   endtask

   task automatic test_reset_abort();
      int n;
      bit seen;
      out_ready = 1'b1;
      op = 5'd20; a = 32'h7654321F; b = 32'h00000013; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL abort_state out_valid=%b in_ready=%b exp out_valid=0 in_ready=1", out_valid, in_ready);
      end
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (out_valid) seen = 1'b1;
         @(posedge clk); #1;
      end
      checks++;
      if (seen !== 1'b0) begin failures++; $display("FAIL abort_no_result got out_valid=1 exp=0"); end
      run_and_check("div_after_abort", 5'd21, 32'hDEADBEEF, 32'h00001234, 1);
   endtask

   initial begin
      clk = 1'b0; rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      op = '0; a = '0; b = '0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      test_base_directed();
      test_base_random();
      test_back_to_back();
      test_mul();
      test_div();
      test_backpressure();
      test_reset_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
